// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath width default,
// the bubble encoding and the fetch FSM state encoding.
package fetch_stage_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DRAIN = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Ready-based instruction-memory port between the fetch stage (master) and imem (slave).
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, and any cycle
// without a load writes a bubble so a stale instruction is never replayed.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pcplus4_in,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pcplus4,
    output logic            valid
);

    logic [31:0]     instr_reg;
    logic [XLEN-1:0] pcplus4_reg;
    logic            valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_reg   <= NOP_INSTR;
            pcplus4_reg <= '0;
            valid_reg   <= 1'b0;
        end else if (flush) begin
            instr_reg   <= NOP_INSTR;
            pcplus4_reg <= '0;
            valid_reg   <= 1'b0;
        end else if (stall) begin
            instr_reg   <= instr_reg;
            pcplus4_reg <= pcplus4_reg;
            valid_reg   <= valid_reg;
        end else if (load) begin
            instr_reg   <= instr_in;
            pcplus4_reg <= pcplus4_in;
            valid_reg   <= 1'b1;
        end else begin
            instr_reg   <= NOP_INSTR;
            pcplus4_reg <= '0;
            valid_reg   <= 1'b0;
        end
    end

    assign instr   = instr_reg;
    assign pcplus4 = pcplus4_reg;
    assign valid   = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, imem request FSM
// and the IF/ID register feeding decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    fetch_stage_if.master   imem,
    output logic [XLEN-1:0] pc_f,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pcplus4_d,
    output logic            valid_d
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_e    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] redir_reg, redir_next;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_target;
    logic            redirect;
    logic            accept;

    assign pc_plus4        = pc_reg + XLEN'(4);
    assign redirect        = jump | branch_taken;
    assign redirect_target = (jump ? jump_target : branch_target) & ALIGN_MASK;
    assign accept          = (state_reg == ST_FETCH) & imem.imem_ready & ~stall_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_BOOT;
            pc_reg    <= PC_RESET;
            redir_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            redir_reg <= redir_next;
        end
    end

    // A redirect that arrives while a request is still outstanding is parked in
    // redir_reg so the address seen by imem stays stable until it completes.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        redir_next = redir_reg;
        case (state_reg)
            ST_BOOT: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (!stall_f) begin
                    if (imem.imem_ready) begin
                        pc_next = redirect ? redirect_target : pc_plus4;
                    end else if (redirect) begin
                        redir_next = redirect_target;
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (imem.imem_ready) begin
                    pc_next    = redir_reg;
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_reg;
        case (state_reg)
            ST_FETCH: imem.imem_req = 1'b1;
            ST_DRAIN: imem.imem_req = 1'b1;
            default:  imem.imem_req = 1'b0;
        endcase
    end

    assign pc_f = pc_reg;

    if_id_reg #(
        .XLEN(XLEN)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_d),
        .stall      (stall_d),
        .load       (accept),
        .instr_in   (imem.imem_rdata),
        .pcplus4_in (pc_plus4),
        .instr      (instr_d),
        .pcplus4    (pcplus4_d),
        .valid      (valid_d)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst2_n;
    logic        stall_f, stall_d, flush_d, jump, branch_taken;
    logic [31:0] jump_target, branch_target;
    logic [31:0] pc_f, instr_d, pcplus4_d;
    logic        valid_d;
    logic [31:0] pc_f2, instr_d2, pcplus4_d2;
    logic        valid_d2;

    fetch_stage_if #(.XLEN(32)) imem  ();
    fetch_stage_if #(.XLEN(32)) imem2 ();

    fetch_stage #(.XLEN(32), .PC_RESET(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (imem),
        .pc_f          (pc_f),
        .instr_d       (instr_d),
        .pcplus4_d     (pcplus4_d),
        .valid_d       (valid_d)
    );

    fetch_stage #(.XLEN(32), .PC_RESET(32'hFFFF_FFFC)) dut_wrap (
        .clk           (clk),
        .rst_n         (rst2_n),
        .stall_f       (1'b0),
        .stall_d       (1'b0),
        .flush_d       (1'b0),
        .jump          (1'b0),
        .jump_target   (32'h0),
        .branch_taken  (1'b0),
        .branch_target (32'h0),
        .imem          (imem2),
        .pc_f          (pc_f2),
        .instr_d       (instr_d2),
        .pcplus4_d     (pcplus4_d2),
        .valid_d       (valid_d2)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem2.imem_ready = 1'b1;
    assign imem2.imem_rdata = mem_word(imem2.imem_addr);

    int checks = 0;
    int errors = 0;

    // Behavioural model: where the PC is, whether we are waiting out a boot
    // cycle or an abandoned request, and what IF/ID must hold.
    logic [31:0] m_pc, m_redir, m_instr, m_pc4;
    logic        m_valid, m_boot, m_drain;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_redir = 32'h0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_boot  = 1'b1;
        m_drain = 1'b0;
    endtask

    task automatic model_step();
        logic        acc;
        logic [31:0] tgt;
        acc = !m_boot && !m_drain && imem.imem_ready && !stall_f;
        if (flush_d) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (stall_d) begin
            // IF/ID keeps its contents
        end else if (acc) begin
            m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        end else begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end
        tgt = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_drain) begin
            if (imem.imem_ready) begin
                m_pc = m_redir; m_drain = 1'b0;
            end
        end else if (!stall_f) begin
            if (imem.imem_ready)
                m_pc = (jump || branch_taken) ? tgt : m_pc + 32'd4;
            else if (jump || branch_taken) begin
                m_redir = tgt; m_drain = 1'b1;
            end
        end
    endtask

    task automatic compare();
        chk("imem_req", {31'b0, imem.imem_req}, {31'b0, !m_boot});
        if (!m_boot) chk("imem_addr", imem.imem_addr, m_pc);
        chk("pc_f", pc_f, m_pc);
        chk("instr_d", instr_d, m_instr);
        chk("pcplus4_d", pcplus4_d, m_pc4);
        chk("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
    endtask

    // Apply one cycle of inputs at the falling edge, clock it, check at the next falling edge.
    task automatic cycle(input logic sf, input logic sd, input logic fl,
                         input logic j, input logic [31:0] jt,
                         input logic b, input logic [31:0] bt, input logic rdy);
        stall_f = sf; stall_d = sd; flush_d = fl;
        jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
        imem.imem_ready = rdy;
        imem.imem_rdata = rdy ? mem_word(imem.imem_addr) : $urandom;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        stall_f = 0; stall_d = 0; flush_d = 0; jump = 0; branch_taken = 0;
        jump_target = 0; branch_target = 0;
        imem.imem_ready = 0; imem.imem_rdata = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        chk("rst_pc", pc_f, 32'h0);
        chk("rst_valid", {31'b0, valid_d}, 32'h0);
        chk("rst_instr", instr_d, 32'h0);

        // Reset release: one idle boot cycle, then 0,4,8
        rst_n = 1'b1;
        chk("boot_req", {31'b0, imem.imem_req}, 32'h0);
        idle(1'b1);
        chk("t1_addr0", imem.imem_addr, 32'h0);
        chk("t1_req", {31'b0, imem.imem_req}, 32'h1);
        idle(1'b1);
        chk("t1_addr4", imem.imem_addr, 32'h4);
        chk("t1_instr0", instr_d, mem_word(32'h0));
        chk("t1_valid", {31'b0, valid_d}, 32'h1);
        idle(1'b1);
        chk("t1_addr8", imem.imem_addr, 32'h8);
        chk("t1_pc4", pcplus4_d, 32'h8);

        // imem not ready for three cycles at 0x10
        idle(1'b1);
        idle(1'b1);
        chk("t2_pc", pc_f, 32'h10);
        repeat (3) begin
            idle(1'b0);
            chk("t2_hold_pc", pc_f, 32'h10);
            chk("t2_bubble", {31'b0, valid_d}, 32'h0);
        end
        idle(1'b1);
        chk("t2_instr", instr_d, mem_word(32'h10));
        chk("t2_pc4", pcplus4_d, 32'h14);

        // Jump while the request is stalled by imem
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h403, 1'b0, 32'h0, 1'b0);
        chk("t3_addr_hold", imem.imem_addr, 32'h14);
        idle(1'b0);
        chk("t3_addr_hold2", imem.imem_addr, 32'h14);
        idle(1'b1);
        chk("t3_dropped", {31'b0, valid_d}, 32'h0);
        chk("t3_target", imem.imem_addr, 32'h400);

        // Stall both stages with imem ready
        idle(1'b1);
        chk("t4_pre_instr", instr_d, mem_word(32'h400));
        repeat (2) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            chk("t4_pc_hold", pc_f, 32'h404);
            chk("t4_instr_hold", instr_d, mem_word(32'h400));
        end
        idle(1'b1);
        chk("t4_refetch", instr_d, mem_word(32'h404));
        chk("t4_refetch_pc4", pcplus4_d, 32'h408);

        // Flush beats stall; jump beats branch
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t5_flush_instr", instr_d, 32'h0);
        chk("t5_flush_valid", {31'b0, valid_d}, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h200, 1'b1);
        chk("t5_jump_prio", pc_f, 32'h80);

        // Asynchronous reset in the middle of a drain discards the parked target
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
        chk("t6_drain_pc", pc_f, 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_pc", pc_f, 32'h0);
        chk("t6_async_req", {31'b0, imem.imem_req}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        compare();
        idle(1'b1);
        chk("t6_restart_addr", imem.imem_addr, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 100) < 15, ($urandom % 100) < 15, ($urandom % 100) < 10,
                  ($urandom % 100) < 8, $urandom, ($urandom % 100) < 10, $urandom,
                  ($urandom % 100) < 70);
        end

        // PC wrap from a reset value at the top of the address space
        @(negedge clk);
        rst2_n = 1'b1;
        chk("w_boot_req", {31'b0, imem2.imem_req}, 32'h0);
        chk("w_reset_pc", pc_f2, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("w_addr0", imem2.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("w_addr1", imem2.imem_addr, 32'h0000_0000);
        chk("w_instr", instr_d2, mem_word(32'hFFFF_FFFC));
        chk("w_pc4", pcplus4_d2, 32'h0000_0000);
        chk("w_valid", {31'b0, valid_d2}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
